// File: rtl/matrix_mult_param.sv
// Parametrised N x N matrix multiplier, C = A x B, one multiply-accumulate per clock.
// Start/busy/done handshake, truncate-or-saturate output conversion, sticky overflow flag.

module matrix_mult_param_chk (
  input logic       Clock,
  input logic       reset,
  input logic       busy,
  input logic       done,
  input logic [1:0] state
);

  a_done_pulse: assert property (@(posedge Clock) disable iff (reset) done |=> !done);
  a_done_not_busy: assert property (@(posedge Clock) disable iff (reset) done |-> !busy);
  a_state_legal: assert property (@(posedge Clock) disable iff (reset) state != 2'd3);

endmodule

module matrix_mult_param #(
  parameter int N        = 8,
  parameter int DW       = 8,
  parameter int OW       = 19,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                start,
  input  logic [N*N*DW-1:0]   A,
  input  logic [N*N*DW-1:0]   B,
  output logic [N*N*OW-1:0]   C,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam int LN = $clog2(N);
  localparam int AW = 2 * DW + LN;
  localparam int IW = LN;
  // One spare bit beyond the wider of AW/OW keeps range limits and compares exact.
  localparam int XW = ((AW > OW) ? AW : OW) + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] FINISH  = 2'd2;

  logic [1:0]          state_r;
  logic [IW-1:0]       i_r;
  logic [IW-1:0]       j_r;
  logic [IW-1:0]       k_r;
  logic [N*N*DW-1:0]   a_r;
  logic [N*N*DW-1:0]   b_r;
  logic [N*N*OW-1:0]   result_r;
  logic [AW-1:0]       acc_r;
  logic                sticky_r;

  int                  a_idx_s;
  int                  b_idx_s;
  int                  r_idx_s;
  logic [DW-1:0]       a_el_s;
  logic [DW-1:0]       b_el_s;
  logic [2*DW-1:0]     a_ext_s;
  logic [2*DW-1:0]     b_ext_s;
  logic [2*DW-1:0]     prod_s;
  logic [AW-1:0]       prod_ext_s;
  logic [AW-1:0]       sum_s;
  logic [XW-1:0]       sum_x_s;
  logic [XW-1:0]       max_x_s;
  logic [XW-1:0]       min_x_s;
  logic                over_hi_s;
  logic                under_lo_s;
  logic [OW-1:0]       conv_s;
  logic                conv_ovf_s;

  // Operand selection and exact multiply-accumulate for the current (i, j, k).
  always_comb begin
    a_idx_s = (int'(i_r) * N + int'(k_r)) * DW;
    b_idx_s = (int'(k_r) * N + int'(j_r)) * DW;
    r_idx_s = (int'(i_r) * N + int'(j_r)) * OW;
    a_el_s  = a_r[a_idx_s +: DW];
    b_el_s  = b_r[b_idx_s +: DW];
    if (SIGNED != 0) begin
      a_ext_s = {{DW{a_el_s[DW-1]}}, a_el_s};
      b_ext_s = {{DW{b_el_s[DW-1]}}, b_el_s};
    end else begin
      a_ext_s = {{DW{1'b0}}, a_el_s};
      b_ext_s = {{DW{1'b0}}, b_el_s};
    end
    // The low 2*DW bits of the extended product are exact for both signednesses.
    prod_s = a_ext_s * b_ext_s;
    if (SIGNED != 0) begin
      prod_ext_s = {{LN{prod_s[2*DW-1]}}, prod_s};
      sum_x_s    = 'x;
    end else begin
      prod_ext_s = {{LN{1'b0}}, prod_s};
      sum_x_s    = 'x;
    end
    sum_s = acc_r + prod_ext_s;
    if (SIGNED != 0) begin
      sum_x_s = {{(XW-AW){sum_s[AW-1]}}, sum_s};
    end else begin
      sum_x_s = {{(XW-AW){1'b0}}, sum_s};
    end
  end

  // Conversion of the full-precision sum to the OW-bit result and its overflow flag.
  always_comb begin
    if (SIGNED != 0) begin
      max_x_s    = (XW'(1) << (OW - 1)) - XW'(1);
      min_x_s    = ~max_x_s;
      over_hi_s  = $signed(sum_x_s) > $signed(max_x_s);
      under_lo_s = $signed(sum_x_s) < $signed(min_x_s);
    end else begin
      max_x_s    = (XW'(1) << OW) - XW'(1);
      min_x_s    = {XW{1'b0}};
      over_hi_s  = sum_x_s > max_x_s;
      under_lo_s = 1'b0;
    end
    if ((SATURATE != 0) && over_hi_s) begin
      conv_s = max_x_s[OW-1:0];
    end else if ((SATURATE != 0) && under_lo_s) begin
      conv_s = min_x_s[OW-1:0];
    end else begin
      conv_s = sum_x_s[OW-1:0];
    end
    conv_ovf_s = over_hi_s | under_lo_s;
  end

  // Control FSM, index walk, accumulator, result array and registered outputs.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      i_r      <= {IW{1'b0}};
      j_r      <= {IW{1'b0}};
      k_r      <= {IW{1'b0}};
      a_r      <= {(N*N*DW){1'b0}};
      b_r      <= {(N*N*DW){1'b0}};
      result_r <= {(N*N*OW){1'b0}};
      acc_r    <= {AW{1'b0}};
      sticky_r <= 1'b0;
      C        <= {(N*N*OW){1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= A;
            b_r      <= B;
            acc_r    <= {AW{1'b0}};
            sticky_r <= 1'b0;
            i_r      <= {IW{1'b0}};
            j_r      <= {IW{1'b0}};
            k_r      <= {IW{1'b0}};
            busy     <= 1'b1;
            ovf      <= 1'b0;
            state_r  <= COMPUTE;
          end else begin
            state_r <= IDLE;
          end
        end
        COMPUTE: begin
          if (k_r == LAST) begin
            result_r[r_idx_s +: OW] <= conv_s;
            sticky_r <= sticky_r | conv_ovf_s;
            acc_r    <= {AW{1'b0}};
            k_r      <= {IW{1'b0}};
            if (j_r == LAST) begin
              j_r <= {IW{1'b0}};
              if (i_r == LAST) begin
                i_r     <= {IW{1'b0}};
                state_r <= FINISH;
              end else begin
                i_r <= i_r + IW'(1);
              end
            end else begin
              j_r <= j_r + IW'(1);
            end
          end else begin
            acc_r <= sum_s;
            k_r   <= k_r + IW'(1);
          end
        end
        FINISH: begin
          C       <= result_r;
          done    <= 1'b1;
          ovf     <= sticky_r;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  matrix_mult_param_chk u_chk (
    .Clock (Clock),
    .reset (reset),
    .busy  (busy),
    .done  (done),
    .state (state_r)
  );

endmodule

// File: tb/tb_matrix_mult_param.sv
// Scoreboard bench for matrix_mult_param: four configurations driven with directed matrices;
// a negedge monitor pops expected results whenever a DUT pulses done.

module tb_matrix_mult_param;

  logic          Clock = 1'b0;
  logic          reset;
  logic [3:0]    st;
  logic [511:0]  A;
  logic [511:0]  B;
  logic [1215:0] c0;
  logic [511:0]  c1;
  logic [511:0]  c2;
  logic [511:0]  c3;
  logic [3:0]    busy_v;
  logic [3:0]    done_v;
  logic [3:0]    ovf_v;

  typedef struct {
    logic [1215:0] c;
    logic          o;
    int            cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  matrix_mult_param u_def (
    .Clock(Clock), .reset(reset), .start(st[0]), .A(A), .B(B), .C(c0),
    .busy(busy_v[0]), .done(done_v[0]), .ovf(ovf_v[0]));

  matrix_mult_param #(.N(8), .DW(8), .OW(8), .SIGNED(1), .SATURATE(1)) u_ss (
    .Clock(Clock), .reset(reset), .start(st[1]), .A(A), .B(B), .C(c1),
    .busy(busy_v[1]), .done(done_v[1]), .ovf(ovf_v[1]));

  matrix_mult_param #(.N(8), .DW(8), .OW(8), .SIGNED(1), .SATURATE(0)) u_st (
    .Clock(Clock), .reset(reset), .start(st[2]), .A(A), .B(B), .C(c2),
    .busy(busy_v[2]), .done(done_v[2]), .ovf(ovf_v[2]));

  matrix_mult_param #(.N(8), .DW(8), .OW(8), .SIGNED(0), .SATURATE(0)) u_ut (
    .Clock(Clock), .reset(reset), .start(st[3]), .A(A), .B(B), .C(c3),
    .busy(busy_v[3]), .done(done_v[3]), .ovf(ovf_v[3]));

  function automatic logic [511:0] fill_in(input logic [7:0] v);
    logic [511:0] r;
    for (int e = 0; e < 64; e++) r[e*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [511:0] ident();
    logic [511:0] r;
    r = '0;
    for (int d = 0; d < 8; d++) r[(d*8+d)*8 +: 8] = 8'd1;
    return r;
  endfunction

  function automatic logic [511:0] ramp_in();
    logic [511:0] r;
    for (int e = 0; e < 64; e++) r[e*8 +: 8] = 8'(e);
    return r;
  endfunction

  function automatic logic [1215:0] fill19(input logic [18:0] v);
    logic [1215:0] r;
    for (int e = 0; e < 64; e++) r[e*19 +: 19] = v;
    return r;
  endfunction

  function automatic logic [1215:0] ramp19();
    logic [1215:0] r;
    for (int e = 0; e < 64; e++) r[e*19 +: 19] = 19'(e);
    return r;
  endfunction

  function automatic logic [1215:0] fill8(input logic [7:0] v);
    logic [1215:0] r;
    r = '0;
    for (int e = 0; e < 64; e++) r[e*8 +: 8] = v;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_c(input string name, input logic [1215:0] act, input logic [1215:0] exp,
                       input int ow);
    logic [1215:0] m;
    logic [1215:0] ae;
    logic [1215:0] ee;
    int idx;
    idx = -1;
    m = (1216'(1) << ow) - 1216'(1);
    for (int e = 0; e < 64; e++) begin
      if (idx < 0 && (((act >> (e*ow)) & m) !== ((exp >> (e*ow)) & m))) idx = e;
    end
    total++;
    if (idx >= 0) begin
      bad++;
      ae = (act >> (idx*ow)) & m;
      ee = (exp >> (idx*ow)) & m;
      $display("FAIL %s elem=%0d act=%h exp=%h", name, idx, ae[18:0], ee[18:0]);
    end
  endtask

  task automatic got_done(input int id, input logic [1215:0] c, input logic o);
    exp_t e;
    logic have;
    have = 1'b0;
    case (id)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      3: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
      default: ;
    endcase
    if (!have) begin
      total++;
      bad++;
      $display("FAIL unexpected_done dut=%0d act=1 exp=0", id);
    end else begin
      chk_c($sformatf("C_dut%0d", id), c, e.c, (id == 0) ? 19 : 8);
      chk($sformatf("ovf_dut%0d", id), int'(o), int'(e.o));
      chk($sformatf("latency_dut%0d", id), cyc, e.cyc);
    end
  endtask

  // Monitor: every done pulse is checked against the oldest expectation of that DUT.
  always @(negedge Clock) begin
    if (done_v[0]) got_done(0, c0, ovf_v[0]);
    if (done_v[1]) got_done(1, {704'b0, c1}, ovf_v[1]);
    if (done_v[2]) got_done(2, {704'b0, c2}, ovf_v[2]);
    if (done_v[3]) got_done(3, {704'b0, c3}, ovf_v[3]);
  end

  task automatic push_exp(input int id, input logic [1215:0] ec, input logic eo, input int dc);
    exp_t e;
    e.c = ec;
    e.o = eo;
    e.cyc = dc;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: ;
    endcase
  endtask

  // Leaves the caller at the negedge right after the accepting edge.
  task automatic issue(input int id, input logic [511:0] a, input logic [511:0] b,
                       input logic [1215:0] ec, input logic eo);
    @(negedge Clock);
    A = a;
    B = b;
    st[id] = 1'b1;
    @(negedge Clock);
    st[id] = 1'b0;
    push_exp(id, ec, eo, cyc + 513);
  endtask

  task automatic wait_done(input int id, output int bc);
    bit seen;
    seen = 1'b0;
    bc = 0;
    for (int t = 0; t < 700; t++) begin
      if (done_v[id]) begin
        seen = 1'b1;
        break;
      end
      if (busy_v[id]) bc++;
      @(negedge Clock);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout_dut%0d act=no_done exp=done", id);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    reset = 1'b1;
    st = 4'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge Clock);
    chk_c("reset_C", c0, '0, 19);
    chk("reset_busy", int'(busy_v), 0);
    chk("reset_done", int'(done_v), 0);
    chk("reset_ovf", int'(ovf_v), 0);
    reset = 1'b0;

    issue(0, ident(), ramp_in(), ramp19(), 1'b0);
    wait_done(0, bc);
    chk("busy_cycles", bc, 513);

    // Ignored starts mid-operation and on the FINISH edge; the one after is accepted.
    issue(0, fill_in(8'hFF), fill_in(8'h01), fill19(19'h7FFF8), 1'b0);
    repeat (99) @(negedge Clock);
    A = fill_in(8'h00);
    st[0] = 1'b1;
    @(negedge Clock);
    st[0] = 1'b0;
    chk_c("C_hold_mid", c0, ramp19(), 19);
    chk("busy_mid", int'(busy_v[0]), 1);
    repeat (412) @(negedge Clock);
    chk_c("C_hold_late", c0, ramp19(), 19);
    A = fill_in(8'h01);
    B = fill_in(8'h01);
    st[0] = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    st[0] = 1'b0;
    chk("busy_reaccept", int'(busy_v[0]), 1);
    push_exp(0, fill19(19'd8), 1'b0, cyc + 513);
    wait_done(0, bc);

    // Reset mid-operation aborts with no result.
    issue(0, ident(), ramp_in(), ramp19(), 1'b0);
    repeat (199) @(negedge Clock);
    reset = 1'b1;
    #1;
    chk_c("abort_C", c0, '0, 19);
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_done", int'(done_v[0]), 0);
    chk("abort_ovf", int'(ovf_v[0]), 0);
    void'(q0.pop_back());
    @(negedge Clock);
    reset = 1'b0;
    issue(0, fill_in(8'hFF), ident(), fill19(19'h7FFFF), 1'b0);
    wait_done(0, bc);

    issue(1, fill_in(8'd127), fill_in(8'd127), fill8(8'h7F), 1'b1);
    wait_done(1, bc);
    issue(1, fill_in(8'h80), fill_in(8'd127), fill8(8'h80), 1'b1);
    wait_done(1, bc);
    issue(2, fill_in(8'd127), fill_in(8'd127), fill8(8'h08), 1'b1);
    wait_done(2, bc);
    issue(3, fill_in(8'hFF), fill_in(8'hFF), fill8(8'h08), 1'b1);
    wait_done(3, bc);

    repeat (3) @(negedge Clock);
    chk("queues_drained", q0.size() + q1.size() + q2.size() + q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
